// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder.
// Turns raw scan bytes from the receiver into {ext, rel, code} key events.
// Handles the E0 (extended), F0 (break) and E1 (pause) prefixes, drops the
// E0 12 / E0 59 "fake shift" bytes and tracks Shift/Ctrl/Alt levels.
// Events are queued in a first-word fall-through FIFO popped via EVT_RD.
// Optional build macro TYPEMATIC_FILTER_EN suppresses auto-repeat makes of the
// most recently pressed key.
module ps2_scan_decoder #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] CODE,
  input  logic       NEW_CODE,
  input  logic       EVT_RD,
  output logic       EVT_VALID,
  output logic [7:0] EVT_CODE,
  output logic       EVT_EXT,
  output logic       EVT_REL,
  output logic       EVT_FULL,
  output logic       OVERFLOW,
  output logic       ERR,
  output logic       SHIFT,
  output logic       CTRL,
  output logic       ALT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CodeE0     = 8'hE0;
  localparam logic [7:0] CodeE1     = 8'hE1;
  localparam logic [7:0] CodeF0     = 8'hF0;
  localparam logic [7:0] CodeNull   = 8'h00;
  localparam logic [7:0] CodeOvrrun = 8'hFF;
  localparam logic [7:0] CodeLShift = 8'h12;
  localparam logic [7:0] CodeRShift = 8'h59;
  localparam logic [7:0] CodeCtrl   = 8'h14;
  localparam logic [7:0] CodeAlt    = 8'h11;

  typedef enum logic [2:0] {
    StIdle,
    StGotE0,
    StGotF0,
    StGotE0F0,
    StSkipE1
  } state_e;

  // ---------------------------------------------------------------------------
  // Byte strobe
  // ---------------------------------------------------------------------------
  logic prev_new_code_q;
  logic byte_stb;

  // Register NEW_CODE so only its rising edge produces a strobe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_new_code_q <= 1'b0;
    end else begin
      prev_new_code_q <= NEW_CODE;
    end
  end

  assign byte_stb = NEW_CODE & ~prev_new_code_q;

  logic is_fake_shift;
  assign is_fake_shift = (CODE == CodeLShift) || (CODE == CodeRShift);

  // ---------------------------------------------------------------------------
  // Prefix FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // State, pause-skip counter and prefix timeout registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      skip_q  <= 3'd0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic: advance on each byte, abandon a stalled prefix on timeout.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = '0;
    if (byte_stb) begin
      case (state_q)
        StIdle: begin
          if (CODE == CodeE0) begin
            state_d = StGotE0;
          end else if (CODE == CodeF0) begin
            state_d = StGotF0;
          end else if (CODE == CodeE1) begin
            state_d = StSkipE1;
            skip_d  = 3'd7;
          end
        end
        StGotE0: begin
          if (CODE == CodeF0) begin
            state_d = StGotE0F0;
          end else if (CODE != CodeE0) begin
            state_d = StIdle;
          end
        end
        StGotF0:   state_d = StIdle;
        StGotE0F0: state_d = StIdle;
        StSkipE1: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d = StIdle;
          end
        end
        default:   state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (tmo_q == TmoLast) begin
        state_d = StIdle;
        skip_d  = 3'd0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  logic       emit_valid;
  logic [7:0] emit_code;
  logic       emit_ext;
  logic       emit_rel;
  logic       err_set;

  // Output decode: which byte, if any, becomes an event on this strobe.
  always_comb begin
    emit_valid = 1'b0;
    emit_code  = CODE;
    emit_ext   = 1'b0;
    emit_rel   = 1'b0;
    err_set    = 1'b0;
    if (byte_stb) begin
      case (state_q)
        StIdle: begin
          if ((CODE == CodeNull) || (CODE == CodeOvrrun)) begin
            err_set = 1'b1;
          end else if ((CODE != CodeE0) && (CODE != CodeF0)) begin
            // E1 itself falls through here and is reported as a plain make.
            emit_valid = 1'b1;
          end
        end
        StGotE0: begin
          if ((CODE != CodeF0) && (CODE != CodeE0) && !is_fake_shift) begin
            emit_valid = 1'b1;
            emit_ext   = 1'b1;
          end
        end
        StGotF0: begin
          emit_valid = 1'b1;
          emit_rel   = 1'b1;
        end
        StGotE0F0: begin
          if (!is_fake_shift) begin
            emit_valid = 1'b1;
            emit_ext   = 1'b1;
            emit_rel   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Typematic filter
  // ---------------------------------------------------------------------------
  logic evt_accept;

`ifdef TYPEMATIC_FILTER_EN
  logic       last_valid_q;
  logic       last_ext_q;
  logic [7:0] last_code_q;
  logic       last_match;

  assign last_match = last_valid_q && (last_ext_q == emit_ext) && (last_code_q == emit_code);
  assign evt_accept = emit_valid && !(last_match && !emit_rel);

  // Remember the last make; a matching break re-arms the filter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_valid_q <= 1'b0;
      last_ext_q   <= 1'b0;
      last_code_q  <= 8'h00;
    end else if (evt_accept && !emit_rel) begin
      last_valid_q <= 1'b1;
      last_ext_q   <= emit_ext;
      last_code_q  <= emit_code;
    end else if (emit_valid && emit_rel && last_match) begin
      last_valid_q <= 1'b0;
    end
  end
`else
  assign evt_accept = emit_valid;
`endif

  // ---------------------------------------------------------------------------
  // Modifier levels and sticky error flags
  // ---------------------------------------------------------------------------
  logic shift_q, ctrl_q, alt_q, err_q, overflow_q;
  logic full, empty, do_push, do_pop;

  // Track modifier make/break even if the FIFO drops the event.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q <= 1'b0;
      ctrl_q  <= 1'b0;
      alt_q   <= 1'b0;
    end else if (evt_accept) begin
      if (!emit_ext && ((emit_code == CodeLShift) || (emit_code == CodeRShift))) begin
        shift_q <= ~emit_rel;
      end
      if (emit_code == CodeCtrl) begin
        ctrl_q <= ~emit_rel;
      end
      if (emit_code == CodeAlt) begin
        alt_q <= ~emit_rel;
      end
    end
  end

  // Sticky overrun and FIFO-overflow indications.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (err_set) begin
        err_q <= 1'b1;
      end
      if (evt_accept && full && !do_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic [9:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [9:0]  head;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = EVT_RD && !empty;
  // A pop on the same edge frees the slot the push needs.
  assign do_push = evt_accept && (!full || do_pop);

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage array, no reset needed since outputs are gated by empty.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {emit_ext, emit_rel, emit_code};
    end
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  assign EVT_VALID = !empty;
  assign EVT_CODE  = empty ? 8'h00 : head[7:0];
  assign EVT_REL   = empty ? 1'b0 : head[8];
  assign EVT_EXT   = empty ? 1'b0 : head[9];
  assign EVT_FULL  = full;
  assign OVERFLOW  = overflow_q;
  assign ERR       = err_q;
  assign SHIFT     = shift_q;
  assign CTRL      = ctrl_q;
  assign ALT       = alt_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed scenarios plus a random byte stream,
// all checked against a flag-based reference decoder and a queue FIFO model.
module tb_ps2_scan_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 64;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] CODE = 8'h00;
  logic       NEW_CODE = 1'b0;
  logic       EVT_RD = 1'b0;
  logic       EVT_VALID, EVT_EXT, EVT_REL, EVT_FULL, OVERFLOW, ERR, SHIFT, CTRL, ALT;
  logic [7:0] EVT_CODE;

  ps2_scan_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST), .CODE(CODE), .NEW_CODE(NEW_CODE), .EVT_RD(EVT_RD),
    .EVT_VALID(EVT_VALID), .EVT_CODE(EVT_CODE), .EVT_EXT(EVT_EXT), .EVT_REL(EVT_REL),
    .EVT_FULL(EVT_FULL), .OVERFLOW(OVERFLOW), .ERR(ERR),
    .SHIFT(SHIFT), .CTRL(CTRL), .ALT(ALT)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: prefix flags, pending skip count, event queue.
  bit         m_ext, m_rel;
  int         m_skip;
  logic [9:0] m_q [$];
  bit         m_shift, m_ctrl, m_alt, m_err, m_ovf;
  bit         lm_valid, lm_ext;
  logic [7:0] lm_code;
  logic [7:0] pool [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_rel = 0; m_skip = 0;
    m_q.delete();
    m_shift = 0; m_ctrl = 0; m_alt = 0; m_err = 0; m_ovf = 0;
    lm_valid = 0; lm_ext = 0; lm_code = 8'h00;
  endtask

  task automatic model_emit(input logic [7:0] c, input bit ext, input bit rel);
    bit same;
    same = lm_valid && (lm_ext == ext) && (lm_code == c);
`ifdef TYPEMATIC_FILTER_EN
    if (!rel && same) return;
    if (!rel) begin
      lm_valid = 1; lm_ext = ext; lm_code = c;
    end else if (same) begin
      lm_valid = 0;
    end
`endif
    if (!ext && (c == 8'h12 || c == 8'h59)) m_shift = !rel;
    if (c == 8'h14) m_ctrl = !rel;
    if (c == 8'h11) m_alt = !rel;
    if (m_q.size() == DEPTH) m_ovf = 1;
    else m_q.push_back({ext, rel, c});
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit fake;
    fake = (b == 8'h12) || (b == 8'h59);
    if (m_skip > 0) begin
      m_skip--;
    end else if (m_rel) begin
      if (!(m_ext && fake)) model_emit(b, m_ext, 1'b1);
      m_ext = 0; m_rel = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_rel = 1;
      else if (b != 8'hE0) begin
        if (!fake) model_emit(b, 1'b1, 1'b0);
        m_ext = 0;
      end
    end else begin
      case (b)
        8'hE0: m_ext = 1;
        8'hF0: m_rel = 1;
        8'hE1: begin m_skip = 7; model_emit(b, 1'b0, 1'b0); end
        8'h00, 8'hFF: m_err = 1;
        default: model_emit(b, 1'b0, 1'b0);
      endcase
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge CLK); #1;
    CODE = b; NEW_CODE = 1'b1;
    model_byte(b);
    repeat (hold) @(posedge CLK);
    #1 NEW_CODE = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic check_status(input string tag);
    @(negedge CLK);
    check({tag, "_shift"}, SHIFT, m_shift);
    check({tag, "_ctrl"}, CTRL, m_ctrl);
    check({tag, "_alt"}, ALT, m_alt);
    check({tag, "_err"}, ERR, m_err);
    check({tag, "_ovf"}, OVERFLOW, m_ovf);
    check({tag, "_valid"}, EVT_VALID, m_q.size() > 0);
    check({tag, "_full"}, EVT_FULL, m_q.size() == DEPTH);
  endtask

  task automatic pop_one(input string tag);
    @(posedge CLK); #1 EVT_RD = 1'b1;
    @(negedge CLK);
    check({tag, "_head"}, {EVT_VALID, EVT_EXT, EVT_REL, EVT_CODE}, {1'b1, m_q[0]});
    @(posedge CLK); #1 EVT_RD = 1'b0;
    void'(m_q.pop_front());
  endtask

  task automatic drain(input string tag);
    while (m_q.size() > 0) pop_one(tag);
    check_status({tag, "_drained"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pool = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h1C, 8'h1C, 8'h1C, 8'h75,
             8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'hFF, 8'h23, 8'h7C};
    model_reset();

    // Reset state
    #12;
    @(negedge CLK);
    check("rst_outs", {EVT_VALID, EVT_CODE, EVT_EXT, EVT_REL, EVT_FULL, OVERFLOW, ERR,
                       SHIFT, CTRL, ALT}, 17'h0);
    @(posedge CLK); #1 RST = 1'b1;
    check_status("rst");

    // Plain make/break and one-cycle latency
    @(posedge CLK); #1;
    CODE = 8'h1C; NEW_CODE = 1'b1;
    model_byte(8'h1C);
    @(negedge CLK);
    check("lat_before", EVT_VALID, 1'b0);
    @(negedge CLK);
    check("lat_after", EVT_VALID, 1'b1);
    @(posedge CLK); #1 NEW_CODE = 1'b0;
    send_byte(8'hF0, 1); send_byte(8'h1C, 1);
    drain("makebrk");

    // Extended keys and fake shift
    send_byte(8'hE0, 1); send_byte(8'h75, 1);
    send_byte(8'hE0, 1); send_byte(8'hF0, 1); send_byte(8'h75, 2);
    send_byte(8'hE0, 1); send_byte(8'h12, 1); send_byte(8'hE0, 1); send_byte(8'h7C, 1);
    drain("ext");

    // Long NEW_CODE pulse gives a single event
    send_byte(8'h1C, 5);
    drain("hold");
    send_byte(8'hF0, 1); send_byte(8'h1C, 1);
    drain("hold_rel");

    // Shift level tracking
    send_byte(8'h12, 1);
    check_status("shift_make");
    send_byte(8'h1C, 1); send_byte(8'hF0, 1); send_byte(8'h12, 1);
    check_status("shift_brk");
    drain("shift");
    send_byte(8'hF0, 1); send_byte(8'h1C, 1);
    drain("shift_rel");

    // Overflow, then simultaneous push and pop while full
    for (int i = 0; i < DEPTH + 2; i++) send_byte(8'h20 + 8'(i), 1);
    check_status("ovf");
    @(posedge CLK); #1;
    CODE = 8'h30; NEW_CODE = 1'b1; EVT_RD = 1'b1;
    @(negedge CLK);
    check("pp_head", {EVT_VALID, EVT_EXT, EVT_REL, EVT_CODE}, {1'b1, m_q[0]});
    @(posedge CLK); #1;
    EVT_RD = 1'b0; NEW_CODE = 1'b0;
    void'(m_q.pop_front());
    model_byte(8'h30);
    check_status("pushpop");
    drain("ovf");

    // Prefix timeout
    send_byte(8'hE0, 1);
    repeat (TMO + 4) @(posedge CLK);
    m_ext = 0; m_rel = 0; m_skip = 0;
    send_byte(8'h1C, 1);
    drain("tmo");
    send_byte(8'hF0, 1); send_byte(8'h1C, 1);

    // Pause sequence
    send_byte(8'hE1, 1);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(1, 254)), 1);
    send_byte(8'h1C, 1);
    drain("pause");
    send_byte(8'hF0, 1); send_byte(8'h1C, 1);
    drain("pause_rel");

    // Overrun byte
    send_byte(8'hFF, 1);
    check_status("err");

    // Auto-repeat
    send_byte(8'h1C, 1); send_byte(8'h1C, 1); send_byte(8'h1C, 1);
    send_byte(8'hF0, 1); send_byte(8'h1C, 1);
    drain("typematic");

    // Reset mid-prefix
    send_byte(8'hE0, 1);
    @(posedge CLK); #1 RST = 1'b0;
    model_reset();
    check_status("rst_mid");
    @(posedge CLK); #1 RST = 1'b1;
    send_byte(8'h1C, 1);
    drain("rst_mid");

    // Random byte stream
    for (int i = 0; i < 200; i++) begin
      send_byte(pool[$urandom_range(0, 15)], int'($urandom_range(1, 3)));
      if ($urandom_range(0, 3) == 0) check_status("rnd");
      if ($urandom_range(0, 2) == 0 || m_q.size() >= DEPTH) drain("rnd");
    end
    drain("rnd_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
